load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit for the 5-stage RV32I core. Takes the ALU result as the effective address, plus store data and access size from decode. Runs one data-memory transaction at a time over a req/gnt/rvalid handshake, and returns sign- or zero-extended load data to writeback. Holds the pipeline via a busy signal while a transaction is outstanding.

## Interface
- No parameters; address and data are fixed at 32 bits.
- clk  input  1  core clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- lsu_req_ip  input  1  single-cycle request pulse from EX; ignored unless the FSM is in IDLE
- lsu_we_ip  input  1  1 = store, 0 = load
- lsu_size_ip  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word
- lsu_sign_ext_ip  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- lsu_addr_ip  input  32  effective address, taken from the ALU result
- lsu_wdata_ip  input  32  store data (rs2 value)
- lsu_busy_op  output  1  pipeline stall request
- lsu_rdata_op  output  32  extended load data
- lsu_rvalid_op  output  1  one-cycle completion pulse, for loads and stores
- lsu_misaligned_op  output  1  one-cycle misaligned-access pulse
- data_req_op  output  1  memory request
- data_gnt_ip  input  1  memory grant
- data_rvalid_ip  input  1  memory response valid
- data_rdata_ip  input  32  memory read data
- data_addr_op  output  32  word address, {addr[31:2], 2'b00}
- data_we_op  output  1  write enable
- data_be_op  output  4  byte enables
- data_wdata_op  output  32  lane-replicated store data

## Operation
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID.
- Transitions:
  - IDLE → WAIT_GNT on lsu_req_ip when the access is aligned.
  - WAIT_GNT → WAIT_RVALID on data_gnt_ip.
  - WAIT_RVALID → IDLE on data_rvalid_ip.
- On accept, the unit registers the following. They stay stable until the next accept.
  - data_addr_op, data_we_op, data_be_op, data_wdata_op
  - the size, the sign flag, and the byte offset addr[1:0]
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- Store data: byte replicated as {4{wdata[7:0]}}; half as {2{wdata[15:0]}}; word passed through.
- Load data:
  1. Shift data_rdata_ip right by offset*8.
  2. Keep the low 8 bits (byte), 16 bits (half) or 32 bits (word).
  3. Extend to 32 bits per lsu_sign_ext_ip.
- Completion: in the cycle after data_rvalid_ip, lsu_rvalid_op = 1 and lsu_rdata_op holds the load result. For stores lsu_rdata_op = 0.
- lsu_rdata_op holds its value until the next completion.
- data_req_op = 1 exactly while in WAIT_GNT. It is never dropped before data_gnt_ip.
- lsu_busy_op = (state != IDLE) | (lsu_req_ip & state == IDLE).
- A request pulse arriving while not in IDLE is dropped. No queuing.
- data_rvalid_ip seen outside WAIT_RVALID and data_gnt_ip seen outside WAIT_GNT are ignored.

## Timing
- Reset values: state IDLE; every output 0, including data_be_op = 4'b0000 and lsu_rdata_op = 0.
- Zero-wait memory (gnt in the first request cycle, rvalid the next cycle), with accept in cycle 0:
  - cycle 0: accept
  - cycle 1: data_req_op = 1, data_gnt_ip = 1
  - cycle 2: data_rvalid_ip = 1
  - cycle 3: lsu_rvalid_op = 1
  - lsu_busy_op is high in cycles 0–2.
- Each extra grant-wait or response-wait cycle adds one cycle of latency and one cycle of busy.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. The outstanding memory transaction is abandoned and no lsu_rvalid_op is produced.
- Back-to-back: a new request may be accepted in the same cycle that lsu_rvalid_op pulses.

## Configuration
- Macro: LSU_MISALIGN_CHECK_EN.
- A misaligned access is a half access with addr[0] = 1, or a word access with addr[1:0] != 0.
- Defined:
  - A misaligned access is not issued; the FSM stays in IDLE.
  - lsu_misaligned_op pulses one cycle after the accept cycle.
  - lsu_rvalid_op is not asserted; lsu_busy_op is high only in the accept cycle.
- Undefined:
  - lsu_misaligned_op is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0], using offset 0.
  - The access is issued normally.

## Test plan
- Store word 0xDEADBEEF to 0x100, zero-wait memory → data_addr_op = 0x100, be = 1111, wdata = 0xDEADBEEF, lsu_rvalid_op in cycle 3.
- Signed load byte from 0x103, rdata = 0x80FF_0000 → be = 1000, lsu_rdata_op = 0xFFFFFF80.
- Unsigned load half from 0x202, rdata = 0xABCD_1234 → be = 1100, lsu_rdata_op = 0x0000ABCD.
- Grant delayed 3 cycles, rvalid delayed 2 cycles → data_req_op held for 4 cycles, busy for 8 cycles (cycles 0–7), completion in cycle 8; a second lsu_req_ip pulse while busy is ignored.
- Word load at 0x101:
  - With the macro: no data_req_op, lsu_misaligned_op pulses once.
  - Without the macro: data_addr_op = 0x100, be = 1111.
- reset_n driven low in WAIT_RVALID, then data_rvalid_ip arrives after release → all outputs 0, FSM in IDLE, no lsu_rvalid_op.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the data memory.
// One transaction at a time over a req/gnt/rvalid handshake.
// The master modport is the load/store unit; the slave modport is the memory.
interface load_store_unit_if;

  logic        data_req_op;
  logic        data_gnt_ip;
  logic        data_rvalid_ip;
  logic [31:0] data_rdata_ip;
  logic [31:0] data_addr_op;
  logic        data_we_op;
  logic [3:0]  data_be_op;
  logic [31:0] data_wdata_op;

  modport master (
    output data_req_op,
    output data_addr_op,
    output data_we_op,
    output data_be_op,
    output data_wdata_op,
    input  data_gnt_ip,
    input  data_rvalid_ip,
    input  data_rdata_ip
  );

  modport slave (
    input  data_req_op,
    input  data_addr_op,
    input  data_we_op,
    input  data_be_op,
    input  data_wdata_op,
    output data_gnt_ip,
    output data_rvalid_ip,
    output data_rdata_ip
  );

endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the 5-stage RV32I core.
// Accepts one request from EX while idle, runs a single req/gnt/rvalid
// transaction on the data bus and returns extended load data to writeback.
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses are rejected with a one-cycle
//               lsu_misaligned_op pulse and never reach the bus
//   undefined : low address bits that do not fit the size are ignored and
//               the access is issued normally; lsu_misaligned_op stays 0
module load_store_unit (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               lsu_req_ip,
  input  logic               lsu_we_ip,
  input  logic [1:0]         lsu_size_ip,
  input  logic               lsu_sign_ext_ip,
  input  logic [31:0]        lsu_addr_ip,
  input  logic [31:0]        lsu_wdata_ip,
  output logic               lsu_busy_op,
  output logic [31:0]        lsu_rdata_op,
  output logic               lsu_rvalid_op,
  output logic               lsu_misaligned_op,
  load_store_unit_if.master  mem
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t      state;

  // Bus-side registers, stable from one accept to the next
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;

  // Access attributes kept for shaping the returned load data
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  offset;

  logic        accept;
  logic        misaligned;
  logic        issue;

  // Byte lanes touched by an access of the given size at the given address.
  function automatic logic [3:0] byte_enables(input logic [1:0] sz,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] store_lanes(input logic [1:0]  sz,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = 32'h0000_0000;
    case (sz)
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      2'b10:   lanes = wdata;
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Lane offset of the access; halves and words drop the bits they cannot use.
  function automatic logic [1:0] lane_offset(input logic [1:0] sz,
                                             input logic [1:0] addr_lo);
    logic [1:0] off;
    off = 2'b00;
    case (sz)
      2'b00:   off = addr_lo;
      2'b01:   off = {addr_lo[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  // Move the addressed lanes down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic        sgn);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = rdata >> {off, 3'b000};
    result  = 32'h0000_0000;
    case (sz)
      2'b00:   result = {{24{sgn & shifted[7]}},  shifted[7:0]};
      2'b01:   result = {{16{sgn & shifted[15]}}, shifted[15:0]};
      2'b10:   result = shifted;
      default: result = shifted;
    endcase
    return result;
  endfunction

`ifdef LSU_MISALIGN_CHECK_EN
  // A half needs an even address, a word needs a word-aligned address.
  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (sz)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo;
      default: bad = |addr_lo;
    endcase
    return bad;
  endfunction

  assign misaligned = accept & is_misaligned(lsu_size_ip, lsu_addr_ip[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Requests are only taken while idle; anything else is dropped.
  assign accept = lsu_req_ip & (state == IDLE);
  assign issue  = accept & ~misaligned;

  // Stall the pipeline for the whole transaction, including the accept cycle.
  assign lsu_busy_op = (state != IDLE) | (lsu_req_ip & (state == IDLE));

  assign mem.data_req_op   = data_req;
  assign mem.data_addr_op  = data_addr;
  assign mem.data_we_op    = data_we;
  assign mem.data_be_op    = data_be;
  assign mem.data_wdata_op = data_wdata;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      data_req          <= 1'b0;
      data_addr         <= 32'h0000_0000;
      data_we           <= 1'b0;
      data_be           <= 4'b0000;
      data_wdata        <= 32'h0000_0000;
      size              <= 2'b00;
      sign_ext          <= 1'b0;
      offset            <= 2'b00;
      lsu_rdata_op      <= 32'h0000_0000;
      lsu_rvalid_op     <= 1'b0;
      lsu_misaligned_op <= 1'b0;
    end else begin
      lsu_rvalid_op     <= 1'b0;
      lsu_misaligned_op <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            state      <= WAIT_GNT;
            data_req   <= 1'b1;
            data_addr  <= {lsu_addr_ip[31:2], 2'b00};
            data_we    <= lsu_we_ip;
            data_be    <= byte_enables(lsu_size_ip, lsu_addr_ip[1:0]);
            data_wdata <= store_lanes(lsu_size_ip, lsu_wdata_ip);
            size       <= lsu_size_ip;
            sign_ext   <= lsu_sign_ext_ip;
            offset     <= lane_offset(lsu_size_ip, lsu_addr_ip[1:0]);
          end else if (misaligned) begin
            lsu_misaligned_op <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_GNT: begin
          // Request stays up until the memory grants it.
          if (mem.data_gnt_ip) begin
            state    <= WAIT_RVALID;
            data_req <= 1'b0;
          end else begin
            data_req <= 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (mem.data_rvalid_ip) begin
            state         <= IDLE;
            lsu_rvalid_op <= 1'b1;
            if (data_we) begin
              lsu_rdata_op <= 32'h0000_0000;
            end else begin
              lsu_rdata_op <= load_extend(mem.data_rdata_ip, size, offset, sign_ext);
            end
          end else begin
            state <= WAIT_RVALID;
          end
        end
        default: begin
          state    <= IDLE;
          data_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases with literal
// expectations, then randomized traffic against a lane-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        reset_n;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic        lsu_sign;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_busy;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic        lsu_mis;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .lsu_req_ip        (lsu_req),
    .lsu_we_ip         (lsu_we),
    .lsu_size_ip       (lsu_size),
    .lsu_sign_ext_ip   (lsu_sign),
    .lsu_addr_ip       (lsu_addr),
    .lsu_wdata_ip      (lsu_wdata),
    .lsu_busy_op       (lsu_busy),
    .lsu_rdata_op      (lsu_rdata),
    .lsu_rvalid_op     (lsu_rvalid),
    .lsu_misaligned_op (lsu_mis),
    .mem               (bus)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model: one pending transaction and the values the bus should show
  bit          m_txn, m_granted, m_req, m_we, m_rvalid, m_mis, m_sign;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic [1:0]  m_size, m_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
  endfunction

  function automatic int lane_base(input logic [1:0] s, input logic [1:0] a);
    int n;
    n = nbytes(s);
    return (int'(a) / n) * n;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] s, input logic [1:0] a);
    logic [3:0] be;
    int n, b;
    n = nbytes(s);
    b = lane_base(s, a);
    for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] s,
                                             input logic sgn, input logic [1:0] a);
    logic [31:0] v;
    int n, b;
    n = nbytes(s);
    b = lane_base(s, a);
    v = 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(b + i) +: 8];
    if (sgn && n < 4 && v[8*n - 1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_txn = 0; m_granted = 0; m_req = 0; m_we = 0; m_rvalid = 0; m_mis = 0; m_sign = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0; m_be = 4'h0; m_size = 2'b00; m_a = 2'b00;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rvalid = 0;
      m_mis    = 0;
      if (!m_txn) begin
        if (lsu_req) begin
          if (MIS_EN && (int'(lsu_addr[1:0]) % nbytes(lsu_size)) != 0) begin
            m_mis = 1;
          end else begin
            m_txn = 1; m_granted = 0; m_req = 1;
            m_addr  = {lsu_addr[31:2], 2'b00};
            m_we    = lsu_we;
            m_be    = model_be(lsu_size, lsu_addr[1:0]);
            m_wdata = model_wdata(lsu_size, lsu_wdata);
            m_size  = lsu_size;
            m_sign  = lsu_sign;
            m_a     = lsu_addr[1:0];
          end
        end
      end else if (!m_granted) begin
        if (bus.data_gnt_ip) begin
          m_granted = 1;
          m_req     = 0;
        end
      end else if (bus.data_rvalid_ip) begin
        m_txn    = 0;
        m_rvalid = 1;
        m_rdata  = m_we ? 32'h0 : model_load(bus.data_rdata_ip, m_size, m_sign, m_a);
      end
    end
  endtask

  // Compare every DUT output against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      check("busy",       32'(lsu_busy),          32'(m_txn | (lsu_req & !m_txn)));
      check("rvalid",     32'(lsu_rvalid),        32'(m_rvalid));
      check("rdata",      lsu_rdata,              m_rdata);
      check("misaligned", 32'(lsu_mis),           32'(m_mis));
      check("data_req",   32'(bus.data_req_op),   32'(m_req));
      check("data_addr",  bus.data_addr_op,       m_addr);
      check("data_we",    32'(bus.data_we_op),    32'(m_we));
      check("data_be",    32'(bus.data_be_op),    32'(m_be));
      check("data_wdata", bus.data_wdata_op,      m_wdata);
    end
  end

  // One clock cycle: model follows the edge, then new inputs are driven.
  task automatic cyc(input logic req, input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic gnt, input logic rv, input logic [31:0] rdata);
    @(posedge clk);
    model_step();
    #1;
    lsu_req = req; lsu_we = we; lsu_size = size; lsu_sign = sgn;
    lsu_addr = addr; lsu_wdata = wdata;
    bus.data_gnt_ip = gnt; bus.data_rvalid_ip = rv; bus.data_rdata_ip = rdata;
    @(negedge clk);
  endtask

  task automatic mem_cyc(input logic gnt, input logic rv, input logic [31:0] rdata);
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, gnt, rv, rdata);
  endtask

  initial begin
    int req_cnt, busy_cnt, rv_cnt;
    reset_n = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00; lsu_sign = 1'b0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    bus.data_gnt_ip = 1'b0; bus.data_rvalid_ip = 1'b0; bus.data_rdata_ip = 32'h0;
    model_reset();
    #3;
    check("reset busy",   32'(lsu_busy),        32'h0);
    check("reset rvalid", 32'(lsu_rvalid),      32'h0);
    check("reset rdata",  lsu_rdata,            32'h0);
    check("reset req",    32'(bus.data_req_op), 32'h0);
    check("reset be",     32'(bus.data_be_op),  32'h0);
    check("reset addr",   bus.data_addr_op,     32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_en = 1'b1;

    // Store word 0xDEADBEEF to 0x100, zero-wait memory
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    check("sw busy c0", 32'(lsu_busy), 32'h1);
    mem_cyc(1'b1, 1'b0, 32'h0);
    check("sw addr",  bus.data_addr_op,      32'h100);
    check("sw be",    32'(bus.data_be_op),   32'hF);
    check("sw wdata", bus.data_wdata_op,     32'hDEADBEEF);
    check("sw we",    32'(bus.data_we_op),   32'h1);
    check("sw req",   32'(bus.data_req_op),  32'h1);
    mem_cyc(1'b0, 1'b1, 32'h12345678);
    check("sw rvalid c2", 32'(lsu_rvalid), 32'h0);
    check("sw busy c2",   32'(lsu_busy),   32'h1);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("sw rvalid c3", 32'(lsu_rvalid), 32'h1);
    check("sw rdata",     lsu_rdata,       32'h0);
    check("sw busy c3",   32'(lsu_busy),   32'h0);

    // Signed load byte from 0x103, then back-to-back unsigned half from 0x202
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_cyc(1'b1, 1'b0, 32'h0);
    check("lb be",   32'(bus.data_be_op), 32'h8);
    check("lb addr", bus.data_addr_op,    32'h100);
    mem_cyc(1'b0, 1'b1, 32'h80FF0000);
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0, 1'b0, 32'h0);
    check("lb rvalid", 32'(lsu_rvalid), 32'h1);
    check("lb rdata",  lsu_rdata,       32'hFFFFFF80);
    check("lhu accept busy", 32'(lsu_busy), 32'h1);
    mem_cyc(1'b1, 1'b0, 32'h0);
    check("lhu be",   32'(bus.data_be_op), 32'hC);
    check("lhu addr", bus.data_addr_op,    32'h200);
    mem_cyc(1'b0, 1'b1, 32'hABCD1234);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("lhu rvalid", 32'(lsu_rvalid), 32'h1);
    check("lhu rdata",  lsu_rdata,       32'h0000ABCD);

    // Grant delayed 3 cycles, rvalid delayed 2 cycles, stray request while busy
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
    req_cnt = 0; busy_cnt = int'(lsu_busy); rv_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc((k == 2) ? 1'b1 : 1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'h55, (k == 4) ? 1'b1 : 1'b0,
          (k == 7) ? 1'b1 : 1'b0, 32'hCAFEF00D);
      req_cnt  += int'(bus.data_req_op);
      busy_cnt += int'(lsu_busy);
      rv_cnt   += int'(lsu_rvalid);
      if (k == 8) check("delay rvalid c8", 32'(lsu_rvalid), 32'h1);
    end
    check("delay req cycles",  32'(req_cnt),  32'd4);
    check("delay busy cycles", 32'(busy_cnt), 32'd8);
    check("delay rvalid count", 32'(rv_cnt),  32'd1);
    check("delay rdata",       lsu_rdata,     32'hCAFEF00D);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("stray req dropped", 32'(bus.data_req_op), 32'h0);

    // Word load at 0x101
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_cyc(1'b0, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis pulse",  32'(lsu_mis),         32'h1);
    check("mis no req", 32'(bus.data_req_op), 32'h0);
    check("mis busy",   32'(lsu_busy),        32'h0);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("mis once",   32'(lsu_mis),         32'h0);
`else
    check("mis addr", bus.data_addr_op,    32'h100);
    check("mis be",   32'(bus.data_be_op), 32'hF);
    check("mis flag", 32'(lsu_mis),        32'h0);
    mem_cyc(1'b1, 1'b0, 32'h0);
    mem_cyc(1'b0, 1'b1, 32'h11223344);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("mis rdata", lsu_rdata, 32'h11223344);
`endif

    // Reset while waiting for the response; late rvalid must be ignored
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_cyc(1'b1, 1'b0, 32'h0);
    mem_cyc(1'b0, 1'b0, 32'h0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst busy",  32'(lsu_busy),        32'h0);
    check("rst rdata", lsu_rdata,            32'h0);
    check("rst req",   32'(bus.data_req_op), 32'h0);
    check("rst be",    32'(bus.data_be_op),  32'h0);
    check("rst addr",  bus.data_addr_op,     32'h0);
    mem_cyc(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    model_step();
    #1;
    reset_n = 1'b1;
    bus.data_rvalid_ip = 1'b1; bus.data_rdata_ip = 32'h87654321;
    @(negedge clk);
    mem_cyc(1'b0, 1'b0, 32'h0);
    check("rst no rvalid", 32'(lsu_rvalid),  32'h0);
    check("rst rdata kept", lsu_rdata,       32'h0);

    // Randomized traffic including stray grants/responses
    for (int c = 0; c < 1500; c++) begin
      logic g, r;
      if (m_txn && !m_granted) g = ($urandom_range(0, 1) == 1);
      else                     g = ($urandom_range(0, 9) == 0);
      if (m_txn && m_granted)  r = ($urandom_range(0, 1) == 1);
      else                     r = ($urandom_range(0, 9) == 0);
      cyc(($urandom_range(0, 2) == 0), 1'($urandom), 2'($urandom), 1'($urandom),
          $urandom, $urandom, g, r, $urandom);
    end
    mem_cyc(1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
